// File: rtl/jtcontra_gfx_tilemap_gen_if.sv
// Bus bundle for the tilemap line renderer: scan RAM read port, SDRAM
// request/response and line buffer write port. The renderer is the master.
interface jtcontra_gfx_tilemap_gen_if #(
    parameter int ROMW  = 16,
    parameter int BPP   = 4,
    parameter int CODEW = 13,
    parameter int WB    = $clog2(8*BPP/ROMW),
    parameter int AW    = CODEW + 3 + WB
);
    // scan RAM
    logic [10:0]      scan_addr;
    logic [CODEW-1:0] code_scan;
    logic [7:0]       attr_scan;
    // SDRAM
    logic             rom_cs;
    logic [AW-1:0]    rom_addr;
    logic             rom_ok;
    logic [ROMW-1:0]  rom_data;
    // line buffer
    logic             line;
    logic             line_we;
    logic [9:0]       line_addr;
    logic [BPP+4:0]   line_din;

    modport master (
        output scan_addr,
        input  code_scan, attr_scan,
        output rom_cs, rom_addr,
        input  rom_ok, rom_data,
        output line, line_we, line_addr, line_din
    );

    modport slave (
        input  scan_addr,
        output code_scan, attr_scan,
        input  rom_cs, rom_addr,
        output rom_ok, rom_data,
        input  line, line_we, line_addr, line_din
    );
endinterface

// File: rtl/jtcontra_gfx_tilemap_gen.sv
// Scroll tilemap line renderer: walks the visible tiles of one line, reads
// code/attributes from the scan RAM, fetches pixel words from SDRAM and
// writes the pixels into one half of a double-buffered line buffer.
module jtcontra_gfx_tilemap_gen #(
    parameter int ROMW  = 16,
    parameter int BPP   = 4,
    parameter int CODEW = 13,
    parameter int HLEN  = 320,
    parameter int WB    = $clog2(8*BPP/ROMW),
    parameter int AW    = CODEW + 3 + WB
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lhbl,
    input  logic       i_lvbl,
    input  logic [8:0] i_vrender,
    input  logic [8:0] i_hscroll,
    input  logic [8:0] i_vscroll,
    input  logic       i_flip,
    output logic       o_done,
    jtcontra_gfx_tilemap_gen_if.master bus
);
    localparam int PPW = ROMW / BPP;             // pixels per ROM word
    localparam int NW  = (8 * BPP) / ROMW;       // ROM words per tile row
    localparam int WBX = (WB > 0) ? WB : 1;      // word counter width, never zero
    localparam int PCX = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic signed [10:0] HLEN_S = 11'(HLEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_LATCH = 3'd3,
        ST_FETCH = 3'd4,
        ST_DUMP  = 3'd5,
        ST_NEXT  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_fsm;
    state_t              w_state_nx;

    logic                r_lhbl_d;
    logic                r_done;
    logic                r_line;
    logic                r_flip;
    logic [5:0]          r_hn;          // tile column
    logic [8:0]          r_vn;          // map row
    logic signed [10:0]  r_x;           // 11 bits so HLEN up to 512 cannot wrap
    logic [CODEW-1:0]    r_code;
    logic [3:0]          r_pal;
    logic                r_prio;
    logic                r_hf;
    logic                r_vf;
    logic [WBX-1:0]      r_w;
    logic [PCX-1:0]      r_pcnt;
    logic [ROMW-1:0]     r_data;
    logic                r_rom_cs;
    logic [AW-1:0]       r_rom_addr;
    logic                r_line_we;
    logic [9:0]          r_line_addr;
    logic [BPP+4:0]      r_line_din;

    logic                w_start;
    logic                w_x_end;
    logic                w_w_last;
    logic                w_in_range;
    logic [8:0]          w_xf;
    logic [BPP-1:0]      w_pix;
    logic                w_unused_bits;

    // Build {code, row, word}; flips mirror the row and the word order.
    function automatic logic [AW-1:0] rom_addr_f(
        input logic [CODEW-1:0] code,
        input logic [2:0]       row,
        input logic [WBX-1:0]   w,
        input logic             hf,
        input logic             vf
    );
        logic [CODEW+3+WBX-1:0] full;
        full = {code, row ^ {3{vf}}, w ^ {WBX{hf}}};
        return AW'(full >> (WBX - WB));
    endfunction

    assign w_start       = i_lhbl & ~r_lhbl_d & i_lvbl;
    assign w_x_end       = (r_x >= HLEN_S);
    assign w_w_last      = (r_w == WBX'(NW - 1));
    assign w_in_range    = ~r_x[10] & (r_x < HLEN_S);
    assign w_xf          = 9'(HLEN - 1) - r_x[8:0];
    assign w_unused_bits = r_vn[8] ^ bus.attr_scan[7];

    // Next state of the tile walk; a start edge always forces INIT.
    always_comb begin
        w_state_fsm = r_state;
        case (r_state)
            ST_IDLE:  w_state_fsm = ST_IDLE;
            ST_INIT:  w_state_fsm = ST_SCAN;
            ST_SCAN:  w_state_fsm = ST_LATCH;
            ST_LATCH: w_state_fsm = ST_FETCH;
            ST_FETCH: begin
                if (bus.rom_ok) begin
                    w_state_fsm = ST_DUMP;
                end else begin
                    w_state_fsm = ST_FETCH;
                end
            end
            ST_DUMP: begin
                if (r_pcnt == PCX'(PPW - 1)) begin
                    w_state_fsm = ST_NEXT;
                end else begin
                    w_state_fsm = ST_DUMP;
                end
            end
            ST_NEXT: begin
                if (w_x_end) begin
                    w_state_fsm = ST_IDLE;
                end else if (!w_w_last) begin
                    w_state_fsm = ST_FETCH;
                end else begin
                    w_state_fsm = ST_SCAN;
                end
            end
            default:  w_state_fsm = ST_IDLE;
        endcase
        w_state_nx = w_start ? ST_INIT : w_state_fsm;
    end

    // Pixel at the head of the shift register: MSBs normally, LSBs when h-flipped.
    always_comb begin
        w_pix = '0;
        if (r_hf) begin
            w_pix = r_data[BPP-1:0];
        end else begin
            w_pix = r_data[ROMW-1 -: BPP];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath and registered outputs for each stage of the tile walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lhbl_d    <= 1'b1;
            r_done      <= 1'b1;
            r_line      <= 1'b0;
            r_flip      <= 1'b0;
            r_hn        <= 6'd0;
            r_vn        <= 9'd0;
            r_x         <= 11'sd0;
            r_code      <= '0;
            r_pal       <= 4'd0;
            r_prio      <= 1'b0;
            r_hf        <= 1'b0;
            r_vf        <= 1'b0;
            r_w         <= '0;
            r_pcnt      <= '0;
            r_data      <= '0;
            r_rom_cs    <= 1'b0;
            r_rom_addr  <= '0;
            r_line_we   <= 1'b0;
            r_line_addr <= 10'd0;
            r_line_din  <= '0;
        end else begin
            r_lhbl_d  <= i_lhbl;
            r_line_we <= 1'b0;
            if (w_start) begin
                r_line   <= ~r_line;
                r_done   <= 1'b0;
                r_rom_cs <= 1'b0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        r_hn   <= i_hscroll[8:3];
                        r_vn   <= (i_vrender ^ {9{i_flip}}) + i_vscroll;
                        r_x    <= -$signed({8'd0, i_hscroll[2:0]});
                        r_flip <= i_flip;
                    end
                    ST_LATCH: begin
                        r_code     <= bus.code_scan;
                        r_pal      <= bus.attr_scan[3:0];
                        r_hf       <= bus.attr_scan[4];
                        r_vf       <= bus.attr_scan[5];
                        r_prio     <= bus.attr_scan[6];
                        r_w        <= '0;
                        r_rom_addr <= rom_addr_f(bus.code_scan, r_vn[2:0], '0,
                                                 bus.attr_scan[4], bus.attr_scan[5]);
                        r_rom_cs   <= 1'b1;
                    end
                    ST_FETCH: begin
                        if (bus.rom_ok) begin
                            r_data   <= bus.rom_data;
                            r_rom_cs <= 1'b0;
                            r_pcnt   <= '0;
                        end
                    end
                    ST_DUMP: begin
                        r_line_we   <= w_in_range;
                        r_line_addr <= {r_line, r_flip ? w_xf : r_x[8:0]};
                        r_line_din  <= {r_prio, r_pal, w_pix};
                        r_x         <= r_x + 11'sd1;
                        r_pcnt      <= r_pcnt + PCX'(1);
                        r_data      <= r_hf ? (r_data >> BPP) : (r_data << BPP);
                    end
                    ST_NEXT: begin
                        if (w_x_end) begin
                            r_done <= 1'b1;
                        end else if (!w_w_last) begin
                            r_w        <= r_w + WBX'(1);
                            r_rom_addr <= rom_addr_f(r_code, r_vn[2:0], r_w + WBX'(1),
                                                     r_hf, r_vf);
                            r_rom_cs   <= 1'b1;
                        end else begin
                            r_hn <= r_hn + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_done        = r_done;
    assign bus.scan_addr = {r_vn[7:3], r_hn};
    assign bus.rom_cs    = r_rom_cs;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.line      = r_line;
    assign bus.line_we   = r_line_we;
    assign bus.line_addr = r_line_addr;
    assign bus.line_din  = r_line_din;
endmodule

// File: tb/tb_jtcontra_gfx_tilemap_gen.sv
// Scoreboard bench for the tilemap line renderer: expected line-buffer writes
// are computed from map coordinates and queued when a line starts; a monitor
// pops and compares on every write strobe.
module tb_jtcontra_gfx_tilemap_gen;
    localparam int HLEN = 320;

    logic       clk = 1'b0;
    logic       rst;
    logic       lhbl, lvbl, flip;
    logic [8:0] vrender, hscroll, vscroll;
    logic       o_done;

    jtcontra_gfx_tilemap_gen_if #(.ROMW(16), .BPP(4), .CODEW(13)) bus ();

    jtcontra_gfx_tilemap_gen dut (
        .clk       (clk),
        .rst       (rst),
        .i_lhbl    (lhbl),
        .i_lvbl    (lvbl),
        .i_vrender (vrender),
        .i_hscroll (hscroll),
        .i_vscroll (vscroll),
        .i_flip    (flip),
        .o_done    (o_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [12:0] mem_code [2048];
    logic [7:0]  mem_attr [2048];
    logic [18:0] exp_q [$];
    logic        exp_line = 1'b0;
    bit          rom_fixed = 1'b0;
    bit          slow = 1'b0;

    function automatic logic [15:0] rom_word(input logic [16:0] a);
        logic [31:0] h;
        if (rom_fixed) return a[0] ? 16'h5678 : 16'h1234;
        h = {15'd0, a} * 32'h9E3779B1;
        return h[31:16] ^ h[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%0h need=%0h", nm, act, req);
        end
    endtask

    // Reference: every screen x maps to map position hscroll+x on row v.
    task automatic push_line(input logic [8:0] hs, input logic [8:0] vs,
                             input logic [8:0] vr, input logic fl, input logic lb);
        logic [8:0]  v, h, xa;
        logic [10:0] sa;
        logic [7:0]  at;
        logic [15:0] d;
        logic [3:0]  pix;
        int px, src, k;
        v = (vr ^ {9{fl}}) + vs;
        for (int x = 0; x < HLEN; x++) begin
            h   = hs + 9'(x);
            sa  = {v[7:3], h[8:3]};
            at  = mem_attr[sa];
            px  = int'(h[2:0]);
            src = at[4] ? 7 - px : px;
            k   = src % 4;
            d   = rom_word({mem_code[sa], v[2:0] ^ {3{at[5]}}, 1'(src / 4)});
            pix = d[15 - 4*k -: 4];
            xa  = fl ? 9'(HLEN - 1 - x) : 9'(x);
            exp_q.push_back({lb, xa, at[6], at[3:0], pix});
        end
    endtask

    task automatic fill_mem(input bit rnd, input logic [12:0] c, input logic [7:0] a);
        for (int i = 0; i < 2048; i++) begin
            mem_code[i] = rnd ? 13'($urandom) : c;
            mem_attr[i] = rnd ? 8'($urandom) : a;
        end
    endtask

    task automatic start_line(input logic [8:0] hs, input logic [8:0] vs,
                              input logic [8:0] vr, input logic fl, input logic vb);
        @(negedge clk);
        lhbl = 1'b0; hscroll = hs; vscroll = vs; vrender = vr; flip = fl; lvbl = vb;
        @(negedge clk);
        lhbl = 1'b1;
        @(posedge clk);
        #1;
        if (vb) begin
            exp_line = ~exp_line;
            exp_q.delete();
            chk("line_toggle", 32'(bus.line), 32'(exp_line));
            chk("done_low", 32'(o_done), 32'd0);
            push_line(hs, vs, vr, fl, exp_line);
        end else begin
            chk("lvbl_done_held", 32'(o_done), 32'd1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", 32'(n < 6000), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("writes_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rnd_line();
        start_line(9'($urandom), 9'($urandom), 9'($urandom), 1'($urandom), 1'b1);
    endtask

    // Scan RAM with one cycle of read latency.
    initial begin : scan_ram
        logic [10:0] prev;
        prev = 11'd0;
        bus.code_scan = 13'd0;
        bus.attr_scan = 8'd0;
        forever begin
            @(negedge clk);
            bus.code_scan = mem_code[prev];
            bus.attr_scan = mem_attr[prev];
            prev = bus.scan_addr;
        end
    end

    // SDRAM responder: one-cycle rom_ok pulse after a variable wait.
    initial begin : rom_resp
        int dly;
        dly = 0;
        bus.rom_ok = 1'b0;
        bus.rom_data = 16'd0;
        forever begin
            @(negedge clk);
            if (bus.rom_ok) begin
                bus.rom_ok = 1'b0;
            end else if (bus.rom_cs) begin
                if (dly == 0) begin
                    bus.rom_ok = 1'b1;
                    bus.rom_data = rom_word(bus.rom_addr);
                    dly = slow ? 20 : $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: compare every line-buffer write with the scoreboard head.
    initial begin : monitor
        logic [18:0] act, req;
        logic [16:0] prev_addr;
        logic        prev_cs;
        prev_cs = 1'b0;
        prev_addr = 17'd0;
        forever begin
            @(negedge clk);
            if (bus.line_we === 1'b1) begin
                act = {bus.line_addr, bus.line_din};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write act=%h need=none", act);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        n_err++;
                        $display("FAIL line_write act=%h need=%h", act, req);
                    end
                end
            end
            if (bus.rom_cs === 1'b1) begin
                n_vec++;
                if (bus.line_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL write_during_fetch act=%b need=0", bus.line_we);
                end
            end
            if (prev_cs && bus.rom_cs === 1'b1) begin
                n_vec++;
                if (bus.rom_addr !== prev_addr) begin
                    n_err++;
                    $display("FAIL rom_addr_stable act=%h need=%h", bus.rom_addr, prev_addr);
                end
            end
            prev_cs = (bus.rom_cs === 1'b1);
            prev_addr = bus.rom_addr;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=running need=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        rst = 1'b1; lhbl = 1'b1; lvbl = 1'b1; flip = 1'b0;
        vrender = 9'd0; hscroll = 9'd0; vscroll = 9'd0;
        fill_mem(1'b0, 13'd5, 8'h03);
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(o_done), 32'd1);
        chk("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
        chk("rst_line_we", 32'(bus.line_we), 32'd0);
        chk("rst_line", 32'(bus.line), 32'd0);
        chk("rst_line_din", 32'(bus.line_din), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done", 32'(o_done), 32'd1);

        // directed lines: fixed tile, scroll, flips, screen flip
        rom_fixed = 1'b1;
        start_line(9'd0, 9'd0, 9'd16, 1'b0, 1'b1); wait_done();
        start_line(9'd3, 9'd0, 9'd16, 1'b0, 1'b1); wait_done();
        fill_mem(1'b0, 13'd5, 8'h30);
        start_line(9'd0, 9'd0, 9'd18, 1'b0, 1'b1); wait_done();
        fill_mem(1'b0, 13'd5, 8'h03);
        start_line(9'd0, 9'd0, 9'd16, 1'b1, 1'b1); wait_done();

        // random map and ROM, slow ROM first
        rom_fixed = 1'b0;
        fill_mem(1'b1, 13'd0, 8'd0);
        slow = 1'b1;
        rnd_line(); wait_done();
        slow = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fill_mem(1'b1, 13'd0, 8'd0);
            rnd_line(); wait_done();
        end

        // restart mid-line
        rnd_line();
        repeat ($urandom_range(100, 400)) @(negedge clk);
        rnd_line(); wait_done();

        // start edge during vertical blank is ignored
        start_line(9'd0, 9'd0, 9'd0, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        chk("lvbl_idle_done", 32'(o_done), 32'd1);
        lvbl = 1'b1;

        // reset in the middle of pixel output
        rnd_line();
        n = 0;
        while (bus.line_we !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("saw_write", 32'(n < 1000), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_line = 1'b0;
        chk("mid_rst_done", 32'(o_done), 32'd1);
        chk("mid_rst_line_we", 32'(bus.line_we), 32'd0);
        chk("mid_rst_rom_cs", 32'(bus.rom_cs), 32'd0);
        chk("mid_rst_line", 32'(bus.line), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rnd_line(); wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
